oam_line_scanner: RTL and testbench
===================================

// Module: oam_line_scanner
// PURPOSE
//  Mode-2 (OAM search) engine for the LCD pipeline. On each line start it walks the sprite
//  attribute table through a synchronous OAM read port and finds the sprites that cover line LY.
//  It keeps up to MAX_PER_LINE hits in OAM-index order, in a small indexed result buffer.
//  The pixel fetcher reads that buffer during mode 3.
//  Generalises the fixed 40-entry / 10-per-line DMG search: table depth, per-line limit, scan
//  pacing and 8x8/8x16 mode are all parametrised, and overflow is reported.
// PARAMETERS
//  NUM_SPRITES      40  OAM entries scanned per line (>=1)
//  MAX_PER_LINE     10  result buffer depth (1..NUM_SPRITES)
//  CYCLES_PER_ENTRY 2   clocks between successive OAM reads (>=1)
// PORTS
//  clk           in   1   single clock
//  reset_n       in   1   asynchronous, active-low reset
//  start         in   1   one-cycle pulse: begin scan for line_y
//  line_y        in   8   LY, sampled with start
//  sprite_size   in   1   LCDC.SpriteSize (0 = 8x8, 1 = 8x16), sampled with start
//  sprite_enable in   1   LCDC.SpriteEnable, sampled with start
//  oam_rd_en     out  1   OAM read strobe
//  oam_index     out  $clog2(NUM_SPRITES)  entry being read
//  oam_attr      in   32  SpriteAttributes, valid the cycle after oam_rd_en
//  busy          out  1   scan in progress
//  done          out  1   one-cycle pulse: results valid
//  hit_count     out  $clog2(MAX_PER_LINE+1)  sprites stored for this line
//  overflow      out  1   more than MAX_PER_LINE sprites matched
//  sel_idx       in   $clog2(MAX_PER_LINE)  result slot to read (combinational read)
//  sel_x         out  8   XPosition of slot
//  sel_tile      out  8   tile number of slot, 8x16 LSB already resolved
//  sel_row       out  3   row within tile, YFlip applied
//  sel_flags     out  8   SpriteAttributeFlags of slot
//  sel_oam_index out  $clog2(NUM_SPRITES)  source entry of slot
// BEHAVIOUR
//  - Reset: all outputs 0; FSM = IDLE; buffer contents and hit_count cleared.
//  - FSM states: IDLE -> SCAN -> FINISH -> IDLE.
//    - IDLE -> SCAN: start=1 while sprite_enable=1. On that edge line_y/sprite_size latch,
//      hit_count and overflow clear, and busy=1 next cycle.
//    - IDLE -> FINISH: start=1 while sprite_enable=0. hit_count=0; done pulses the next cycle.
//    - start while busy is ignored.
//  - Reads: if start is sampled at edge t, read k drives oam_rd_en=1, oam_index=k in cycle
//    t+1+k*CPE (CPE = CYCLES_PER_ENTRY). oam_rd_en=0 at all other times.
//  - oam_attr is evaluated the cycle after each read. done=1 and busy=0 in the cycle after the
//    last data cycle. Defaults: reads at t+1, t+3, ..., t+79; done at t+81.
//  - Hit test: diff = {1'b0,LY} + 16 - {1'b0,YPosition}, computed mod 512 (9 bits).
//    hit iff diff < (sprite_size ? 16 : 8). Negative diff wraps large, so it never hits.
//    XPosition is not tested; X=0 sprites are stored.
//  - Row: r = diff[3:0] masked to [2:0] in 8x8 mode. If YFlip: r = height-1-r.
//    - 8x16: sel_tile = {Tile[7:1], r[3]}, sel_row = r[2:0].
//    - 8x8: sel_tile = Tile, sel_row = r[2:0].
//  - Storage: hits are stored in ascending OAM index at slot hit_count, then hit_count increments.
//  - Full buffer: a further hit sets overflow=1 and is dropped. The scan continues, so timing
//    is constant.
//  - Read port: sel_* reflect stored slots at any time and may change mid-scan.
//    sel_idx >= hit_count returns all zeros.
//  - Results persist until the next accepted start.
//  - reset_n low mid-scan aborts immediately: no done; outputs are at their reset values.
// STRUCTURE
//  - Shared package additions: OAM_ENTRY_BITS constants; SPRITE_HEIGHT_8/16; typedef
//    LineSprite {x, tile, row, flags, oam_index}; function SpriteRowHit(line_y, ypos, size)
//    returning hit + row, reused by the fetcher.
//  - FSM, pacing counter and entry counter live in this module.
//  - One sub-module: sprite_line_buffer (MAX_PER_LINE x LineSprite). It has a write-append
//    port, a clear input and a combinational indexed read.
// TESTING
//  1. LY=0, Y=16 at entry 0 (8x8), other entries Y=0 -> hit_count=1, sel_row=0, done at t+81.
//  2. 12 entries with Y=20, LY=5 (8x8) -> hit_count=10, overflow=1, slots = entries 0..9 in order.
//  3. 8x16, Y=16, Tile=0x43, LY=9, YFlip=1 -> r=9, flipped 6: sel_tile=0x42, sel_row=6.
//  4. Y=0xFF, LY=153 (wrap) and Y=0, LY=0 -> no hit, hit_count=0.
//  5. sprite_enable=0 at start -> no oam_rd_en, done at t+2, hit_count=0; repeated start
//     mid-scan -> ignored.
//  6. reset_n low at t+40 -> busy/done/hit_count=0 asynchronously; fresh start completes normally.

Source files
------------

// File: rtl/oam_line_scanner_pkg.sv
// Shared OAM / sprite definitions for the LCD pipeline (scanner and fetcher).
package oam_line_scanner_pkg;

  localparam int OAM_ENTRY_BITS      = 32;
  localparam int OAM_Y_LSB           = 0;
  localparam int OAM_X_LSB           = 8;
  localparam int OAM_TILE_LSB        = 16;
  localparam int OAM_FLAGS_LSB       = 24;
  localparam int FLAG_YFLIP          = 6;
  localparam int LINE_OAM_INDEX_BITS = 8;

  localparam logic [4:0] SPRITE_HEIGHT_8  = 5'd8;
  localparam logic [4:0] SPRITE_HEIGHT_16 = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FINISH
  } ScanState;

  typedef struct packed {
    logic [7:0]                     x;
    logic [7:0]                     tile;
    logic [2:0]                     row;
    logic [7:0]                     flags;
    logic [LINE_OAM_INDEX_BITS-1:0] oam_index;
  } LineSprite;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
  } RowHit;

  // Screen Y is offset by 16 in OAM, so diff is the row inside the sprite;
  // a sprite below the line wraps to a large 9-bit value and never hits.
  function automatic RowHit SpriteRowHit(input logic [7:0] line_y,
                                         input logic [7:0] ypos,
                                         input logic       size);
    RowHit      res;
    logic [8:0] diff;
    logic [8:0] height;
    diff     = {1'b0, line_y} + 9'd16 - {1'b0, ypos};
    height   = size ? 9'(SPRITE_HEIGHT_16) : 9'(SPRITE_HEIGHT_8);
    res.hit  = (diff < height);
    res.row  = size ? diff[3:0] : {1'b0, diff[2:0]};
    return res;
  endfunction

endpackage

// File: rtl/oam_line_scanner_if.sv
// Synchronous OAM read port: strobe + index out, attributes back one cycle later.
interface oam_line_scanner_if
  import oam_line_scanner_pkg::*;
#(
  parameter int IDX_W = 6
);
  logic                      rd_en;
  logic [IDX_W-1:0]          index;
  logic [OAM_ENTRY_BITS-1:0] attr;

  modport master (output rd_en, output index, input attr);
  modport slave  (input rd_en, input index, output attr);
endinterface

// File: rtl/oam_line_scanner_line_buffer.sv
// Per-line sprite result store: append-only during a scan, indexed read for the fetcher.
module sprite_line_buffer
  import oam_line_scanner_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  LineSprite        i_wr_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  input  logic [SEL_W-1:0] i_rd_idx,
  output LineSprite        o_rd_data
);

  LineSprite        r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

  // Append at the current fill level; a clear only rewinds the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_wr_en && !o_full) begin
      r_mem[SEL_W'(r_count)] <= i_wr_data;
      r_count                <= r_count + 1'b1;
    end
  end

  // Slots beyond the fill level read as zero so stale entries never leak out.
  always_comb begin
    o_rd_data = '0;
    if (CNT_W'(i_rd_idx) < r_count) o_rd_data = r_mem[i_rd_idx];
  end

endmodule

// File: rtl/oam_line_scanner.sv
// Mode-2 OAM search: walks the sprite table once per line and keeps the
// first MAX_PER_LINE sprites that cover line LY, flagging any excess.
module oam_line_scanner
  import oam_line_scanner_pkg::*;
#(
  parameter int  NUM_SPRITES      = 40,
  parameter int  MAX_PER_LINE     = 10,
  parameter int  CYCLES_PER_ENTRY = 2,
  localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int CNT_W  = $clog2(MAX_PER_LINE + 1),
  localparam int SEL_W  = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic [7:0]                i_line_y,
  input  logic                      i_sprite_size,
  input  logic                      i_sprite_enable,
  oam_line_scanner_if.master        oam,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [CNT_W-1:0]          o_hit_count,
  output logic                      o_overflow,
  input  logic [SEL_W-1:0]          i_sel_idx,
  output logic [7:0]                o_sel_x,
  output logic [7:0]                o_sel_tile,
  output logic [2:0]                o_sel_row,
  output logic [7:0]                o_sel_flags,
  output logic [IDX_W-1:0]          o_sel_oam_index
);

  localparam int PACE_W = (CYCLES_PER_ENTRY > 1) ? $clog2(CYCLES_PER_ENTRY) : 1;
  localparam logic [PACE_W-1:0] PACE_LAST  = PACE_W'(CYCLES_PER_ENTRY - 1);
  localparam logic [IDX_W-1:0]  ENTRY_LAST = IDX_W'(NUM_SPRITES - 1);

  ScanState          r_state, w_stateNxt;
  logic [PACE_W-1:0] r_pace, w_paceNxt;
  logic [IDX_W-1:0]  r_entry, w_entryNxt;
  logic [7:0]        r_lineY;
  logic              r_size;
  logic              r_evalValid;
  logic [IDX_W-1:0]  r_evalIdx;
  logic              r_done;
  logic              r_overflow;

  logic              w_rdEn;
  logic              w_accept;
  logic              w_full;
  logic              w_evalHit;
  RowHit             w_rowHit;
  logic [3:0]        w_rowFinal;
  LineSprite         w_newSprite;
  LineSprite         w_sel;
  logic              w_unused_selIdxHi;

  // Next-state and read-strobe decode; reads are issued every CYCLES_PER_ENTRY in SCAN.
  always_comb begin
    w_stateNxt = r_state;
    w_paceNxt  = r_pace;
    w_entryNxt = r_entry;
    w_rdEn     = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept   = 1'b1;
          w_paceNxt  = '0;
          w_entryNxt = '0;
          w_stateNxt = i_sprite_enable ? ST_SCAN : ST_FINISH;
        end
      end
      ST_SCAN: begin
        w_rdEn    = (r_pace == '0);
        w_paceNxt = (r_pace == PACE_LAST) ? '0 : r_pace + 1'b1;
        if (w_rdEn) begin
          w_entryNxt = r_entry + 1'b1;
          if (r_entry == ENTRY_LAST) w_stateNxt = ST_FINISH;
        end
      end
      ST_FINISH: w_stateNxt = ST_IDLE;
      default:   w_stateNxt = ST_IDLE;
    endcase
  end

  // FSM, pacing and read-pipeline registers; FINISH covers the last data cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pace      <= '0;
      r_entry     <= '0;
      r_lineY     <= '0;
      r_size      <= 1'b0;
      r_evalValid <= 1'b0;
      r_evalIdx   <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_stateNxt;
      r_pace      <= w_paceNxt;
      r_entry     <= w_entryNxt;
      r_evalValid <= w_rdEn;
      r_evalIdx   <= r_entry;
      r_done      <= (r_state == ST_FINISH);
      if (w_accept && i_sprite_enable) begin
        r_lineY <= i_line_y;
        r_size  <= i_sprite_size;
      end
      if (w_accept)
        r_overflow <= 1'b0;
      else if (w_evalHit && w_full)
        r_overflow <= 1'b1;
    end
  end

  // Hit test and result formatting for the attributes returned by the previous read.
  always_comb begin
    w_newSprite = '0;
    w_rowHit    = SpriteRowHit(r_lineY, oam.attr[OAM_Y_LSB +: 8], r_size);
    w_rowFinal  = w_rowHit.row;
    if (oam.attr[OAM_FLAGS_LSB + FLAG_YFLIP])
      w_rowFinal = (r_size ? 4'd15 : 4'd7) - w_rowHit.row;
    w_newSprite.x         = oam.attr[OAM_X_LSB +: 8];
    w_newSprite.tile      = r_size ? {oam.attr[OAM_TILE_LSB + 1 +: 7], w_rowFinal[3]}
                                   : oam.attr[OAM_TILE_LSB +: 8];
    w_newSprite.row       = w_rowFinal[2:0];
    w_newSprite.flags     = oam.attr[OAM_FLAGS_LSB +: 8];
    w_newSprite.oam_index = LINE_OAM_INDEX_BITS'(r_evalIdx);
  end

  assign w_evalHit = r_evalValid && w_rowHit.hit;

  sprite_line_buffer #(
    .DEPTH (MAX_PER_LINE),
    .CNT_W (CNT_W),
    .SEL_W (SEL_W)
  ) u_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_accept),
    .i_wr_en   (w_evalHit),
    .i_wr_data (w_newSprite),
    .o_count   (o_hit_count),
    .o_full    (w_full),
    .i_rd_idx  (i_sel_idx),
    .o_rd_data (w_sel)
  );

  assign oam.rd_en       = w_rdEn;
  assign oam.index       = w_rdEn ? r_entry : '0;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = r_done;
  assign o_overflow      = r_overflow;
  assign o_sel_x         = w_sel.x;
  assign o_sel_tile      = w_sel.tile;
  assign o_sel_row       = w_sel.row;
  assign o_sel_flags     = w_sel.flags;
  assign o_sel_oam_index = w_sel.oam_index[IDX_W-1:0];
  assign w_unused_selIdxHi = ^w_sel.oam_index;

endmodule

// File: tb/tb_oam_line_scanner.sv
// Self-checking bench for oam_line_scanner with a behavioural OAM search model.
module tb_oam_line_scanner;

  localparam int NUM     = 40;
  localparam int MAXL    = 10;
  localparam int CPE     = 2;
  localparam int IDX_W   = 6;
  localparam int CNT_W   = 4;
  localparam int SEL_W   = 4;
  localparam int DONE_AT = (NUM - 1) * CPE + 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [7:0]       line_y;
  logic             sprite_size;
  logic             sprite_enable;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             overflow;
  logic [SEL_W-1:0] sel_idx;
  logic [7:0]       sel_x;
  logic [7:0]       sel_tile;
  logic [2:0]       sel_row;
  logic [7:0]       sel_flags;
  logic [IDX_W-1:0] sel_oam_index;

  logic [31:0] oam_mem [NUM];
  logic [34:0] expSlot [MAXL];
  int          expCount;
  bit          expOvf;

  int obsDone, obsDonePulses, obsBusyCycles;
  int obsRdCycles[$];
  int obsRdIdx[$];

  int testsRun    = 0;
  int testsFailed = 0;

  oam_line_scanner_if #(.IDX_W(IDX_W)) oam_if ();

  oam_line_scanner #(
    .NUM_SPRITES      (NUM),
    .MAX_PER_LINE     (MAXL),
    .CYCLES_PER_ENTRY (CPE)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_start         (start),
    .i_line_y        (line_y),
    .i_sprite_size   (sprite_size),
    .i_sprite_enable (sprite_enable),
    .oam             (oam_if),
    .o_busy          (busy),
    .o_done          (done),
    .o_hit_count     (hit_count),
    .o_overflow      (overflow),
    .i_sel_idx       (sel_idx),
    .o_sel_x         (sel_x),
    .o_sel_tile      (sel_tile),
    .o_sel_row       (sel_row),
    .o_sel_flags     (sel_flags),
    .o_sel_oam_index (sel_oam_index)
  );

  always #5 clk = ~clk;

  // OAM memory: one-cycle read latency, garbage on the bus when not read
  always @(posedge clk)
    oam_if.attr <= oam_if.rd_en ? oam_mem[oam_if.index] : $urandom();

  // Reference: scan OAM in order with signed arithmetic, keep the first MAXL hits
  task automatic model_line(input logic [7:0] ly, input logic sz);
    int h, d, r;
    logic [31:0] ent;
    logic [7:0]  tile;
    expCount = 0;
    expOvf   = 1'b0;
    for (int i = 0; i < MAXL; i++) expSlot[i] = '0;
    h = sz ? 16 : 8;
    for (int e = 0; e < NUM; e++) begin
      ent = oam_mem[e];
      d = int'(ly) + 16 - int'(ent[7:0]);
      if (d >= 0 && d < h) begin
        if (expCount >= MAXL) expOvf = 1'b1;
        else begin
          r    = ent[30] ? (h - 1 - d) : d;
          tile = ent[23:16];
          if (sz) tile = (tile & 8'hFE) | 8'(r / 8);
          expSlot[expCount] = {ent[15:8], tile, 3'(r % 8), ent[31:24], 8'(e)};
          expCount++;
        end
      end
    end
  endtask

  task automatic fill_hidden();
    for (int e = 0; e < NUM; e++) oam_mem[e] = $urandom() & 32'hFFFF_FF00;
  endtask

  // Pulse start, then record strobes, busy and done for a bounded number of cycles
  task automatic run_scan(input logic [7:0] ly, input logic sz, input logic en,
                          input int cycles, input int restartAt);
    obsRdCycles.delete();
    obsRdIdx.delete();
    obsDone = -1; obsDonePulses = 0; obsBusyCycles = 0;
    @(negedge clk);
    start = 1'b1; line_y = ly; sprite_size = sz; sprite_enable = en;
    @(posedge clk);
    #1;
    start = 1'b0; line_y = 8'($urandom()); sprite_size = 1'($urandom()); sprite_enable = 1'($urandom());
    for (int j = 1; j <= cycles; j++) begin
      @(negedge clk);
      if (oam_if.rd_en) begin
        obsRdCycles.push_back(j);
        obsRdIdx.push_back(int'(oam_if.index));
      end
      if (busy) obsBusyCycles++;
      if (done) begin
        obsDonePulses++;
        if (obsDone < 0) obsDone = j;
      end
      start = (j == restartAt);
      if (j == restartAt) begin
        line_y = ly ^ 8'h55; sprite_enable = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    sel_idx = '0;
    #1;
    testsRun++;
    if ({busy, done, hit_count, overflow, oam_if.rd_en} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {busy, done, hit_count, overflow, oam_if.rd_en});
    end
    testsRun++;
    if ({sel_x, sel_tile, sel_row, sel_flags, sel_oam_index} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_sel: got %h expected 0", {sel_x, sel_tile, sel_row, sel_flags, sel_oam_index});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({busy, done} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_single_hit();
    int bad;
    fill_hidden();
    oam_mem[0] = {8'($urandom()) & 8'hBF, 8'h3C, 8'h25, 8'd16};
    run_scan(8'd0, 1'b0, 1'b1, DONE_AT + 2, 0);
    testsRun++;
    if (obsDone !== DONE_AT) begin
      testsFailed++;
      $display("[TB] FAIL done_cycle: got %0d expected %0d", obsDone, DONE_AT);
    end
    bad = (obsRdCycles.size() != NUM) ? 1 : 0;
    if (bad == 0)
      for (int k = 0; k < NUM; k++)
        if (obsRdCycles[k] != 1 + k * CPE || obsRdIdx[k] != k) bad++;
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL read_schedule: got %0d reads with %0d misplaced, expected %0d every %0d cycles",
               obsRdCycles.size(), bad, NUM, CPE);
    end
    testsRun++;
    if (obsDonePulses !== 1 || obsBusyCycles !== DONE_AT - 1) begin
      testsFailed++;
      $display("[TB] FAIL busy_done: got pulses=%0d busy=%0d expected 1 and %0d",
               obsDonePulses, obsBusyCycles, DONE_AT - 1);
    end
    sel_idx = 4'd0;
    #1;
    testsRun++;
    if (hit_count !== 4'd1 || sel_row !== 3'd0 || sel_tile !== 8'h3C || sel_x !== 8'h25 || sel_oam_index !== 6'd0) begin
      testsFailed++;
      $display("[TB] FAIL single_hit: got cnt=%0d row=%0d tile=%h x=%h idx=%0d expected 1 0 3c 25 0",
               hit_count, sel_row, sel_tile, sel_x, sel_oam_index);
    end
    sel_idx = 4'd1;
    #1;
    testsRun++;
    if ({sel_x, sel_tile, sel_row, sel_flags, sel_oam_index} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL empty_slot: got %h expected 0", {sel_x, sel_tile, sel_row, sel_flags, sel_oam_index});
    end
  endtask

  task automatic test_overflow();
    logic [34:0] obs;
    fill_hidden();
    for (int e = 0; e < 12; e++) oam_mem[e] = {8'($urandom()), 8'($urandom()), 8'(e * 3), 8'd20};
    run_scan(8'd5, 1'b0, 1'b1, DONE_AT + 2, 0);
    model_line(8'd5, 1'b0);
    testsRun++;
    if (int'(hit_count) !== expCount || overflow !== expOvf || expCount != MAXL) begin
      testsFailed++;
      $display("[TB] FAIL overflow: got cnt=%0d ovf=%0d expected %0d %0d", hit_count, overflow, expCount, expOvf);
    end
    for (int i = 0; i < MAXL; i++) begin
      sel_idx = SEL_W'(i);
      #1;
      obs = {sel_x, sel_tile, sel_row, sel_flags, 8'(sel_oam_index)};
      testsRun++;
      if (obs !== expSlot[i]) begin
        testsFailed++;
        $display("[TB] FAIL overflow_slot%0d: got %h expected %h", i, obs, expSlot[i]);
      end
    end
  endtask

  task automatic test_disabled();
    run_scan(8'($urandom()), 1'b0, 1'b0, 6, 0);
    testsRun++;
    if (obsRdCycles.size() != 0 || obsDone !== 2 || obsDonePulses !== 1) begin
      testsFailed++;
      $display("[TB] FAIL disabled_timing: got reads=%0d done@%0d pulses=%0d expected 0 2 1",
               obsRdCycles.size(), obsDone, obsDonePulses);
    end
    testsRun++;
    if (hit_count !== '0 || overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL disabled_clear: got cnt=%0d ovf=%0d expected 0 0", hit_count, overflow);
    end
  endtask

  task automatic test_tall_flip();
    fill_hidden();
    oam_mem[7] = {8'h40, 8'h43, 8'h50, 8'd16};
    run_scan(8'd9, 1'b1, 1'b1, DONE_AT + 2, 0);
    sel_idx = 4'd0;
    #1;
    testsRun++;
    if (hit_count !== 4'd1 || sel_tile !== 8'h42 || sel_row !== 3'd6 || sel_oam_index !== 6'd7 || sel_flags !== 8'h40) begin
      testsFailed++;
      $display("[TB] FAIL tall_flip: got cnt=%0d tile=%h row=%0d idx=%0d flags=%h expected 1 42 6 7 40",
               hit_count, sel_tile, sel_row, sel_oam_index, sel_flags);
    end
  endtask

  task automatic test_no_wrap_hit();
    for (int e = 0; e < NUM; e++) oam_mem[e] = ($urandom() & 32'hFFFF_FF00) | 32'hFF;
    run_scan(8'd153, 1'b1, 1'b1, DONE_AT + 2, 0);
    testsRun++;
    if (hit_count !== '0 || overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_nohit: got cnt=%0d ovf=%0d expected 0 0", hit_count, overflow);
    end
    fill_hidden();
    run_scan(8'd0, 1'b1, 1'b1, DONE_AT + 2, 0);
    testsRun++;
    if (hit_count !== '0) begin
      testsFailed++;
      $display("[TB] FAIL height_edge16: got cnt=%0d expected 0", hit_count);
    end
    fill_hidden();
    oam_mem[3] = {8'h00, 8'h11, 8'h00, 8'd59};
    oam_mem[4] = {8'h00, 8'h22, 8'h00, 8'd58};
    oam_mem[5] = {8'h00, 8'h33, 8'h00, 8'd66};
    run_scan(8'd50, 1'b0, 1'b1, DONE_AT + 2, 0);
    sel_idx = 4'd0;
    #1;
    testsRun++;
    if (hit_count !== 4'd2 || sel_oam_index !== 6'd3 || sel_row !== 3'd7 || sel_x !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL height_edge8_a: got cnt=%0d idx=%0d row=%0d x=%h expected 2 3 7 00",
               hit_count, sel_oam_index, sel_row, sel_x);
    end
    sel_idx = 4'd1;
    #1;
    testsRun++;
    if (sel_oam_index !== 6'd5 || sel_row !== 3'd0 || sel_tile !== 8'h33) begin
      testsFailed++;
      $display("[TB] FAIL height_edge8_b: got idx=%0d row=%0d tile=%h expected 5 0 33",
               sel_oam_index, sel_row, sel_tile);
    end
  endtask

  task automatic test_restart_ignored();
    fill_hidden();
    for (int e = 0; e < 6; e++) oam_mem[e * 5] = {8'($urandom()), 8'($urandom()), 8'($urandom()), 8'(70 + 16 - e)};
    run_scan(8'd70, 1'b0, 1'b1, DONE_AT + 2, 20);
    model_line(8'd70, 1'b0);
    testsRun++;
    if (obsDone !== DONE_AT || obsDonePulses !== 1 || obsRdCycles.size() != NUM) begin
      testsFailed++;
      $display("[TB] FAIL restart_timing: got done@%0d pulses=%0d reads=%0d expected %0d 1 %0d",
               obsDone, obsDonePulses, obsRdCycles.size(), DONE_AT, NUM);
    end
    testsRun++;
    if (int'(hit_count) !== expCount) begin
      testsFailed++;
      $display("[TB] FAIL restart_count: got %0d expected %0d", hit_count, expCount);
    end
  endtask

  task automatic test_reset_abort();
    fill_hidden();
    for (int e = 0; e < 12; e++) oam_mem[e] = {8'h00, 8'($urandom()), 8'($urandom()), 8'd110};
    run_scan(8'd100, 1'b0, 1'b1, 40, 0);
    testsRun++;
    if (hit_count !== 4'd10 || overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midscan_visible: got cnt=%0d ovf=%0d expected 10 1", hit_count, overflow);
    end
    reset_n = 1'b0;
    #1;
    testsRun++;
    if ({busy, done, hit_count, overflow, oam_if.rd_en} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_abort: got %b expected 0", {busy, done, hit_count, overflow, oam_if.rd_en});
    end
    @(negedge clk);
    reset_n = 1'b1;
    obsDonePulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) obsDonePulses++;
    end
    testsRun++;
    if (obsDonePulses !== 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", obsDonePulses);
    end
    run_scan(8'd100, 1'b0, 1'b1, DONE_AT + 2, 0);
    testsRun++;
    if (obsDone !== DONE_AT || hit_count !== 4'd10 || overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL fresh_scan: got done@%0d cnt=%0d ovf=%0d expected %0d 10 1",
               obsDone, hit_count, overflow, DONE_AT);
    end
  endtask

  task automatic test_random();
    logic [7:0]  ly, y;
    logic        sz;
    logic [34:0] obs;
    for (int it = 0; it < 12; it++) begin
      ly = 8'($urandom_range(0, 255));
      sz = 1'($urandom());
      for (int e = 0; e < NUM; e++) begin
        case ($urandom_range(0, 3))
          0:       y = 8'($urandom());
          1:       y = ly + 8'd16 - 8'($urandom_range(0, 17));
          default: y = 8'd0;
        endcase
        oam_mem[e] = {8'($urandom()), 8'($urandom()), 8'($urandom()), y};
      end
      run_scan(ly, sz, 1'b1, DONE_AT + 2, 0);
      model_line(ly, sz);
      testsRun++;
      if (obsDone !== DONE_AT || int'(hit_count) !== expCount || overflow !== expOvf) begin
        testsFailed++;
        $display("[TB] FAIL random%0d_summary: got done@%0d cnt=%0d ovf=%0d expected %0d %0d %0d",
                 it, obsDone, hit_count, overflow, DONE_AT, expCount, expOvf);
      end
      for (int i = 0; i < MAXL; i++) begin
        sel_idx = SEL_W'(i);
        #1;
        obs = {sel_x, sel_tile, sel_row, sel_flags, 8'(sel_oam_index)};
        testsRun++;
        if (obs !== expSlot[i]) begin
          testsFailed++;
          $display("[TB] FAIL random%0d_slot%0d: got %h expected %h", it, i, obs, expSlot[i]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; line_y = '0; sprite_size = 1'b0;
    sprite_enable = 1'b0; sel_idx = '0;
    for (int e = 0; e < NUM; e++) oam_mem[e] = '0;
    test_reset();
    test_single_hit();
    test_overflow();
    test_disabled();
    test_tall_flip();
    test_no_wrap_hit();
    test_restart_ignored();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
